// File: rtl/pong_vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing constants, the
// total-period helper and the receiver lock-FSM state encoding. The VGA
// generator uses the same constants, so both ends agree on the frame shape.
package pong_vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;

   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   // Sync flops idle high for {hsync, vsync}; colour bits idle low.
   localparam logic [4:0] RX_SYNC_IDLE = 5'b11_000;

   // Receiver lock state.
   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_LOCKED = 2'd2
   } rx_state_t;

   // Full period of one axis: active + front porch + sync + back porch.
   function automatic int timing_total(input int active, input int fp,
                                       input int sync_w, input int bp);
      return active + fp + sync_w + bp;
   endfunction

endpackage

// File: rtl/vga_rx_sync.sv
// Two-flop synchronizer plus one edge register for a bundle of async inputs.
// The upper EDGE_W bits get falling-edge detection; the remaining low bits
// are passed through as data, aligned with the edge pulses. Edge pulses are
// held off until the chain holds real samples, so a reset release never
// produces a false edge from the idle reset value.
module vga_rx_sync #(
   parameter int               WIDTH  = 5,
   parameter int               EDGE_W = 2,
   parameter logic [WIDTH-1:0] IDLE   = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          din,
   output logic [WIDTH-EDGE_W-1:0]   data,
   output logic [EDGE_W-1:0]         fall
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] edge_q;
   logic [2:0]       fill_q;

   // Synchronizer stages, edge register and falling-edge pulse generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= IDLE;
         sync_q <= IDLE;
         edge_q <= IDLE;
         fill_q <= '0;
         fall   <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous
         // stage's old value, which is what makes this a shift chain.
         meta_q <= din;
         sync_q <= meta_q;
         edge_q <= sync_q;
         fill_q <= {fill_q[1:0], 1'b1};
         fall   <= fill_q[2] ? (edge_q[WIDTH-1 -: EDGE_W] & ~sync_q[WIDTH-1 -: EDGE_W])
                             : '0;
      end
   end

   assign data = edge_q[WIDTH-EDGE_W-1:0];

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers line/frame timing from hsync/vsync, locks
// after one clean frame, and reports active-area pixels with coordinates.
// Pin-to-output latency is 4 clk (2 sync stages, edge register, output reg).
// Optional feature: define VGA_RX_ERRCNT_EN to add a saturating timing-error
// counter on err_cnt; otherwise err_cnt is tied to 0.
module vga_sync_receiver
   import pong_vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [2:0] rgb,
   output logic       locked,
   output logic       pix_valid,
   output logic [9:0] x_pix,
   output logic [9:0] y_pix,
   output logic [2:0] rgb_out,
   output logic       frame_start,
   output logic       timing_err,
   output logic [7:0] err_cnt
);

   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
   localparam logic [9:0]  X_START   = 10'(H_SYNC + H_BP);
   localparam logic [9:0]  X_STOP    = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0]  Y_START   = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  Y_STOP    = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [9:0]  CNT_MAX   = 10'd1023;

   // Synchronized stage-3 signals.
   logic [2:0] rgb_s;
   logic [1:0] fall;
   logic       hs_fall;
   logic       vs_fall;

   // State and counters; *_q hold the position of the previous stage-3 sample.
   rx_state_t  state_q, state_d;
   logic [9:0] h_cnt_q, v_cnt_q;
   logic       h_seen_q, v_seen_q;   // a reference edge exists since reset
   logic       err_frame_q;          // a line error occurred this frame

   // Combinational results for the current stage-3 sample.
   logic [9:0] h_cur, v_cur;
   logic       line_err, frame_err, frame_bad;
   logic       pix_d;
   logic [9:0] x_d, y_d;

   vga_rx_sync #(
      .WIDTH  (5),
      .EDGE_W (2),
      .IDLE   (RX_SYNC_IDLE)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({hsync, vsync, rgb}),
      .data  (rgb_s),
      .fall  (fall)
   );

   assign hs_fall = fall[1];
   assign vs_fall = fall[0];

   // Counter advance, timing checks, FSM next state and pixel-stage values.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the block leaves a value held and no latch is inferred.
      h_cur     = '0;
      v_cur     = v_cnt_q;
      line_err  = 1'b0;
      frame_err = 1'b0;
      frame_bad = 1'b0;
      state_d   = state_q;
      pix_d     = 1'b0;
      x_d       = '0;
      y_d       = '0;

      if (!hs_fall) begin
         h_cur = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 10'd1;
      end

      // A vsync fall restarts the frame even when an hsync fall coincides.
      if (vs_fall) begin
         v_cur = '0;
      end else if (hs_fall) begin
         v_cur = (v_cnt_q == CNT_MAX) ? CNT_MAX : v_cnt_q + 10'd1;
      end

      // Lengths are only judged once a previous reference edge exists.
      line_err  = hs_fall && h_seen_q && (({1'b0, h_cnt_q} + 11'd1) != H_TOTAL_C);
      frame_err = vs_fall && v_seen_q && (({1'b0, v_cnt_q} + 11'd1) != V_TOTAL_C);
      frame_bad = err_frame_q | line_err | frame_err;

      case (state_q)
         ST_HUNT:   if (vs_fall) state_d = ST_ALIGN;
         ST_ALIGN:  if (vs_fall && !frame_bad) state_d = ST_LOCKED;
         ST_LOCKED: if (line_err || frame_err) state_d = ST_HUNT;
         default:   state_d = ST_HUNT;
      endcase

      pix_d = (state_q == ST_LOCKED) &&
              (h_cur >= X_START) && (h_cur < X_STOP) &&
              (v_cur >= Y_START) && (v_cur < Y_STOP);
      if (pix_d) begin
         x_d = h_cur - X_START;
         y_d = v_cur - Y_START;
      end
   end

   // Lock FSM, position counters and per-frame error tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HUNT;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         h_seen_q    <= 1'b0;
         v_seen_q    <= 1'b0;
         err_frame_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_cnt_q     <= h_cur;
         v_cnt_q     <= v_cur;
         h_seen_q    <= h_seen_q | hs_fall;
         v_seen_q    <= v_seen_q | vs_fall;
         err_frame_q <= vs_fall ? 1'b0 : (err_frame_q | line_err);
      end
   end

   // Output register: pixel data, coordinates and event pulses move together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid   <= 1'b0;
         x_pix       <= '0;
         y_pix       <= '0;
         rgb_out     <= '0;
         frame_start <= 1'b0;
         timing_err  <= 1'b0;
      end else begin
         pix_valid   <= pix_d;
         x_pix       <= x_d;
         y_pix       <= y_d;
         rgb_out     <= pix_d ? rgb_s : 3'd0;
         frame_start <= vs_fall;
         timing_err  <= line_err | frame_err;
      end
   end

   assign locked = (state_q == ST_LOCKED);

`ifdef VGA_RX_ERRCNT_EN
   logic [7:0] err_cnt_q;

   // Saturating count of timing_err pulses, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (timing_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clk cycles.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameter V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1, single clock, one pixel per cycle.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port hsync, input, 1, horizontal sync, active-low.
REQ-008 SHALL have port vsync, input, 1, vertical sync, active-low.
REQ-009 SHALL have port rgb, input, 3, pixel colour {R,G,B}.
REQ-010 SHALL have port locked, output, 1, high while timing is locked.
REQ-011 SHALL have port pix_valid, output, 1, high for locked active-area pixels.
REQ-012 SHALL have ports x_pix and y_pix, output, 10 each, active-area coordinates.
REQ-013 SHALL have port rgb_out, output, 3, colour aligned with x_pix/y_pix.
REQ-014 SHALL have port frame_start, output, 1, one-cycle pulse on each vsync falling edge.
REQ-015 SHALL have port timing_err, output, 1, one-cycle pulse on a line-length or frame-length mismatch.
REQ-016 SHALL have port err_cnt, output, 8, error count (present only with the macro).

Function
REQ-017 SHALL pass hsync, vsync and rgb through 2-flop synchronizers, then detect falling edges on registered sync values.
REQ-018 SHALL reset h_cnt to 0 on each hsync falling edge, else increment by 1, saturating at 1023.
REQ-019 SHALL flag a line error on an hsync falling edge when the preceding h_cnt+1 != H_TOTAL (sum of the horizontal parameters, 800).
REQ-020 SHALL increment v_cnt on each hsync falling edge, reset it to 0 on a vsync falling edge, and saturate it at 1023.
REQ-021 SHALL flag a frame error on a vsync falling edge when line count != V_TOTAL (525).
REQ-022 SHALL implement FSM HUNT->ALIGN->LOCKED:
  - HUNT: first vsync fall -> ALIGN.
  - ALIGN: next vsync fall with no error during the frame -> LOCKED; with any error -> remain in ALIGN and restart the count.
  - LOCKED: any line or frame error -> HUNT.
REQ-023 SHALL assert locked exactly in the LOCKED state.
REQ-024 SHALL assert pix_valid only when LOCKED, h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-025 SHALL make x_pix/y_pix equal to the counters minus their offsets when pix_valid=1, and 0 otherwise.
REQ-026 SHALL register x_pix, y_pix, rgb_out and pix_valid together, with fixed latency of 4 clk from the input pins (2 synchronizer stages, edge register, output register).
REQ-027 SHALL pulse timing_err in any state, one cycle after detection; a simultaneous line and frame error SHALL produce a single pulse.
REQ-028 SHALL, when an hsync fall and a vsync fall occur in the same cycle, apply the vsync reset to v_cnt, reset h_cnt, and evaluate both checks.
REQ-029 SHALL emit frame_start in all states.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set FSM=HUNT, all counters and synchronizers to 0 (sync flops to 1, idle level), and every output to 0.
REQ-031 SHALL treat reset mid-frame like power-up: relock requires a full ALIGN frame, and no spurious frame_start or timing_err SHALL be emitted on release.

Configuration
REQ-032 SHALL, with VGA_RX_ERRCNT_EN defined, increment err_cnt on each timing_err pulse, saturating at 255 and cleared only by reset.
REQ-033 SHALL, without VGA_RX_ERRCNT_EN, tie err_cnt to 0 and synthesize no counter logic.

Structure
REQ-034 SHALL take the default timing constants, H_TOTAL/V_TOTAL derivation and FSM state encoding from shared package pong_vga_pkg, also used by the VGA generator.
REQ-035 SHALL place the synchronizer and edge-detect logic in sub-module vga_rx_sync, instantiated once for all five signals.

Verification
REQ-036 SHALL cover: codebase VGA generator looped back, 3 frames -> locked=1 at the start of frame 3; pixel (0,0) and (639,479) reported with matching rgb_out.
REQ-037 SHALL cover: one line shortened to 799 cycles while LOCKED -> one timing_err pulse, locked=0, relock after 2 clean frames.
REQ-038 SHALL cover: frame of 524 lines -> timing_err at the vsync fall, FSM=HUNT.
REQ-039 SHALL cover: rst_n pulsed low for 3 cycles mid-line -> all outputs 0 immediately, no timing_err after release, locked after 2 full frames.
REQ-040 SHALL cover: 300 injected errors with VGA_RX_ERRCNT_EN defined -> err_cnt=255; rebuilt without the macro -> err_cnt=0.
REQ-041 SHALL cover: pix_valid count per locked frame = 307200 exactly.
